// File: rtl/tas_pkg.sv
// Shared FSM state type and default geometry for the averaging RAM writer.
package tas_pkg;
  localparam int DATA_W_DEF   = 8;
  localparam int AVG_LOG2_DEF = 2;
  localparam int ADDR_W_DEF   = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_WR   = 2'd3
  } tas_state_e;
endpackage

// File: rtl/tas_addr_cntr_p.sv
// RAM write address down-counter; starts at all-ones and pulses wrap
// in the same cycle the address rolls from zero back to all-ones.
module tas_addr_cntr_p #(
  parameter int ADDR_W = 11
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              dec,
  input  logic              clear,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '1;
      wrap <= 1'b0;
    end else if (clear) begin
      addr <= '1;
      wrap <= 1'b0;
    end else begin
      wrap <= dec && (addr == '0);
      if (dec) addr <= addr - 1'b1;
    end
  end

endmodule

// File: rtl/tas_avg_wr.sv
// Pulls samples from a FIFO, averages groups of 2**AVG_LOG2 (or passes them
// through) and writes each result to a descending RAM address.
module tas_avg_wr
  import tas_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              mode_pass,
  input  logic              clear,
  output logic              rd_fifo,
  output logic              ram_wr_n,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              addr_wrap,
  output logic              busy
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] N = CNT_W'(1 << AVG_LOG2);

  tas_state_e        state, state_nx;
  logic [ACC_W-1:0]  acc, acc_sum;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic              mode_q, mode_eff, grp_done;

  // First sample of a group sees the live mode; the rest use the latched copy.
  assign mode_eff = (cnt == '0) ? mode_pass : mode_q;
  assign acc_sum  = (cnt == '0) ? ACC_W'(fifo_data) : acc + ACC_W'(fifo_data);
  assign cnt_inc  = cnt + 1'b1;
  assign grp_done = mode_eff || (cnt_inc == N);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nx = S_RD;
      S_RD:    state_nx = S_CAP;
      S_CAP:   state_nx = grp_done ? S_WR : S_IDLE;
      S_WR:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (clear) state_nx = S_IDLE;
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      mode_q   <= 1'b0;
      ram_data <= '0;
    end else begin
      state <= state_nx;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (state == S_CAP) begin
        acc <= acc_sum;
        cnt <= cnt_inc;
        if (cnt == '0) mode_q <= mode_pass;
        // Loaded on entry to WR so the value holds until the next write.
        if (grp_done) ram_data <= mode_eff ? fifo_data : DATA_W'(acc_sum >> AVG_LOG2);
      end else if (state == S_WR) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

  assign rd_fifo  = (state == S_RD);
  assign ram_wr_n = (state != S_WR);
  assign busy     = (state != S_IDLE);

  tas_addr_cntr_p #(.ADDR_W(ADDR_W)) u_addr (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .dec     (state == S_WR),
    .clear   (clear),
    .addr    (ram_addr),
    .wrap    (addr_wrap)
  );

endmodule
